// File: rtl/botao_evento.sv
// Button gesture classifier: turns a press pulse plus held level into short/long/double events.
// Optional auto-repeat of long press while held: define BOTAO_EVENTO_REPEAT_EN.
module botao_evento #(
  parameter int LONG_CYC   = 1000,
  parameter int DOUBLE_CYC = 500,
  parameter int CNT_W      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       b_pulse,
  input  logic       b_hold,
  output logic       ev_short,
  output logic       ev_long,
  output logic       ev_double,
  output logic [1:0] ev_code,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, HELD, WAIT2, HELD2, LONGREL} state_t;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DOUBLE_CYC - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      ev_short  <= 1'b0;
      ev_long   <= 1'b0;
      ev_double <= 1'b0;
      ev_code   <= 2'd0;
      busy      <= 1'b0;
    end else begin
      ev_short  <= 1'b0;
      ev_long   <= 1'b0;
      ev_double <= 1'b0;
      case (state)
        IDLE: begin
          if (b_pulse) begin
            state <= HELD;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        HELD: begin
          if (!b_hold) begin
            state <= WAIT2;
            cnt   <= '0;
          end else if (cnt == LONG_LAST) begin
            ev_long <= 1'b1;
            ev_code <= 2'd2;
            state   <= LONGREL;
            cnt     <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT2: begin
          // A second press on the expiry edge beats the short event.
          if (b_pulse) begin
            state <= HELD2;
            cnt   <= '0;
          end else if (cnt == DBL_LAST) begin
            ev_short <= 1'b1;
            ev_code  <= 2'd1;
            state    <= IDLE;
            busy     <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD2: begin
          if (!b_hold) begin
            ev_double <= 1'b1;
            ev_code   <= 2'd3;
            state     <= IDLE;
            busy      <= 1'b0;
          end
        end
        LONGREL: begin
          if (!b_hold) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
`ifdef BOTAO_EVENTO_REPEAT_EN
          else if (cnt == LONG_LAST) begin
            ev_long <= 1'b1;
            ev_code <= 2'd2;
            cnt     <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
